// File: rtl/bcd_pkg.sv
// Shared types and constants for the sequential binary-to-BCD converter.
//   BCD_DIGIT_W    : bits per BCD digit
//   BCD_ADJ_THRESH : a digit at or above this value is corrected before shifting
//   BCD_ADJ_ADD    : correction added to such a digit
//   b2b_state_t    : converter FSM states
//   bcd_digit_t    : one BCD digit
package bcd_pkg;

    localparam int unsigned BCD_DIGIT_W = 4;

    typedef logic [3:0] bcd_digit_t;

    localparam bcd_digit_t BCD_ADJ_THRESH = 4'd5;
    localparam bcd_digit_t BCD_ADJ_ADD    = 4'd3;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } b2b_state_t;

endpackage

// File: rtl/bcd_digit_adjust.sv
// Combinational add-3 correction for one BCD digit in the double-dabble datapath.
// Ports:
//   digit_i : digit before correction
//   digit_o : digit_i + 3 when digit_i >= 5, else digit_i (4-bit, no carry out)
module bcd_digit_adjust
    import bcd_pkg::*;
(
    input  bcd_digit_t digit_i,
    output bcd_digit_t digit_o
);

    assign digit_o = (digit_i >= BCD_ADJ_THRESH) ? (digit_i + BCD_ADJ_ADD) : digit_i;

endmodule

// File: rtl/bin_to_bcd_seq.sv
// Sequential binary-to-BCD converter (shift-add-3), one input bit per clock.
// Ports:
//   clk     : clock, rising edge
//   rst_n   : asynchronous active-low reset
//   start_i : conversion request, honoured only while idle
//   bin_i   : unsigned binary value, captured on the accepted start edge
//   busy_o  : high from the cycle after an accepted start through the DONE state
//   done_o  : one-cycle pulse; bcd_o/ovf_o valid from this cycle on
//   bcd_o   : result digits, digit 0 least significant at [3:0]
//   ovf_o   : value did not fit in DIGITS digits; bcd_o holds the low digits
module bin_to_bcd_seq
    import bcd_pkg::*;
#(
    parameter int unsigned BIN_W  = 8,
    parameter int unsigned DIGITS = 3
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          start_i,
    input  logic [BIN_W-1:0]              bin_i,
    output logic                          busy_o,
    output logic                          done_o,
    output logic [BCD_DIGIT_W*DIGITS-1:0] bcd_o,
    output logic                          ovf_o
);

    localparam int unsigned BCD_W = BCD_DIGIT_W * DIGITS;
    localparam int unsigned TOT_W = BCD_W + BIN_W;
    localparam int unsigned CNT_W = $clog2(BIN_W + 1);

    if (BIN_W < 1 || DIGITS < 1) begin : g_param_check
        $fatal(1, "bin_to_bcd_seq: BIN_W and DIGITS must both be >= 1");
    end

    b2b_state_t         r_state;
    logic [BIN_W-1:0]   r_sh_bin;
    logic [BCD_W-1:0]   r_sh_bcd;
    logic               r_ovf_acc;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_busy;
    logic               r_done;
    logic [BCD_W-1:0]   r_bcd;
    logic               r_ovf;

    logic [BCD_W-1:0]   w_adj;
    logic [TOT_W-1:0]   w_shifted;
    logic               w_shift_out;

    for (genvar g = 0; g < DIGITS; g++) begin : g_adj
        bcd_digit_adjust u_adj (
            .digit_i (r_sh_bcd[g*BCD_DIGIT_W +: BCD_DIGIT_W]),
            .digit_o (w_adj[g*BCD_DIGIT_W +: BCD_DIGIT_W])
        );
    end

    // Corrected digits and remaining binary bits shift as one register; the bit
    // leaving the top digit only matters for overflow detection.
    assign w_shifted   = {w_adj, r_sh_bin} << 1;
    assign w_shift_out = w_adj[BCD_W-1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_sh_bin  <= '0;
            r_sh_bcd  <= '0;
            r_ovf_acc <= 1'b0;
            r_cnt     <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_bcd     <= '0;
            r_ovf     <= 1'b0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    r_done <= 1'b0;
                    if (start_i) begin
                        r_sh_bin  <= bin_i;
                        r_sh_bcd  <= '0;
                        r_ovf_acc <= 1'b0;
                        r_cnt     <= CNT_W'(BIN_W);
                        r_busy    <= 1'b1;
                        r_state   <= SHIFT;
                    end
                end
                SHIFT: begin
                    r_sh_bin  <= w_shifted[BIN_W-1:0];
                    r_sh_bcd  <= w_shifted[TOT_W-1:BIN_W];
                    r_ovf_acc <= r_ovf_acc | w_shift_out;
                    r_cnt     <= r_cnt - CNT_W'(1);
                    if (r_cnt == CNT_W'(1)) begin
                        r_state <= DONE;
                    end
                end
                DONE: begin
                    r_bcd   <= r_sh_bcd;
                    r_ovf   <= r_ovf_acc;
                    r_done  <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign busy_o = r_busy;
    assign done_o = r_done;
    assign bcd_o  = r_bcd;
    assign ovf_o  = r_ovf;

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Directed bench for bin_to_bcd_seq: default 3-digit instance plus a 2-digit
// instance fed from the same start/bin stimulus.
module tb_bin_to_bcd_seq;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [7:0]  bin;
    logic        busy,  done,  ovf;
    logic [11:0] bcd;
    logic        busy2, done2, ovf2;
    logic [7:0]  bcd2;

    int errors;
    int checks;

    bin_to_bcd_seq u_dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start_i (start),
        .bin_i   (bin),
        .busy_o  (busy),
        .done_o  (done),
        .bcd_o   (bcd),
        .ovf_o   (ovf)
    );

    bin_to_bcd_seq #(.BIN_W(8), .DIGITS(2)) u_dut2 (
        .clk     (clk),
        .rst_n   (rst_n),
        .start_i (start),
        .bin_i   (bin),
        .busy_o  (busy2),
        .done_o  (done2),
        .bcd_o   (bcd2),
        .ovf_o   (ovf2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Runs one conversion; samples #1 after each edge, k=0 being the start edge.
    // Results are captured in the cycle where done is seen (lat = k, -1 if never).
    task automatic do_conv(input logic [7:0] v,
                           output logic [11:0] r_bcd, output logic r_ovf,
                           output logic [7:0] r_bcd2, output logic r_ovf2,
                           output int lat, output int busy_cnt, output int done_cnt);
        lat = -1; busy_cnt = 0; done_cnt = 0;
        r_bcd = 'x; r_ovf = 1'bx; r_bcd2 = 'x; r_ovf2 = 1'bx;
        @(negedge clk);
        start = 1'b1;
        bin   = v;
        @(posedge clk);
        #1;
        start = 1'b0;
        bin   = 8'hxx;
        for (int k = 0; k <= 12; k++) begin
            if (k > 0) begin
                @(posedge clk);
                #1;
            end
            if (busy === 1'b1) busy_cnt++;
            if (done === 1'b1) begin
                done_cnt++;
                if (lat < 0) begin
                    lat    = k;
                    r_bcd  = bcd;
                    r_ovf  = ovf;
                    r_bcd2 = bcd2;
                    r_ovf2 = ovf2;
                end
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        start = 1'b0;
        bin   = 8'd0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({busy, done, bcd, ovf} !== 15'd0) begin
            errors++;
            $display("FAIL reset_outputs: got busy=%b done=%b bcd=%h ovf=%b, want all zero",
                     busy, done, bcd, ovf);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_zero();
        logic [11:0] b; logic o; logic [7:0] b2; logic o2; int lat, bc, dc;
        do_conv(8'd0, b, o, b2, o2, lat, bc, dc);
        checks++;
        if (lat !== 9) begin
            errors++; $display("FAIL zero_latency: got %0d, want 9", lat);
        end
        checks++;
        if (b !== 12'h000 || o !== 1'b0) begin
            errors++; $display("FAIL zero_value: got bcd=%h ovf=%b, want 000/0", b, o);
        end
        checks++;
        if (dc !== 1) begin
            errors++; $display("FAIL zero_done_pulses: got %0d, want 1", dc);
        end
    endtask

    task automatic test_back_to_back();
        int k;
        @(negedge clk);
        start = 1'b1;
        bin   = 8'd255;
        @(posedge clk);
        #1;
        start = 1'b0;
        k = 0;
        while (done !== 1'b1 && k < 20) begin
            @(posedge clk);
            #1;
            k++;
        end
        checks++;
        if (k !== 9) begin
            errors++; $display("FAIL b2b_first_latency: got %0d, want 9", k);
        end
        checks++;
        if (bcd !== 12'h255 || ovf !== 1'b0) begin
            errors++; $display("FAIL b2b_255: got bcd=%h ovf=%b, want 255/0", bcd, ovf);
        end
        // Request the next conversion while done is still high.
        start = 1'b1;
        bin   = 8'd99;
        @(posedge clk);
        #1;
        start = 1'b0;
        checks++;
        if (busy !== 1'b1 || done !== 1'b0) begin
            errors++; $display("FAIL b2b_accept: got busy=%b done=%b, want 1/0", busy, done);
        end
        k = 0;
        while (done !== 1'b1 && k < 20) begin
            @(posedge clk);
            #1;
            k++;
        end
        checks++;
        if (k !== 9 || bcd !== 12'h099 || ovf !== 1'b0) begin
            errors++;
            $display("FAIL b2b_99: got lat=%0d bcd=%h ovf=%b, want 9/099/0", k, bcd, ovf);
        end
    endtask

    task automatic test_sweep();
        logic [11:0] b, exp_b; logic o; logic [7:0] b2, exp_b2; logic o2, exp_o2;
        int lat, bc, dc;
        for (int v = 0; v < 256; v++) begin
            exp_b  = {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
            exp_b2 = {4'((v / 10) % 10), 4'(v % 10)};
            exp_o2 = (v >= 100);
            do_conv(8'(v), b, o, b2, o2, lat, bc, dc);
            checks++;
            if (b !== exp_b || o !== 1'b0 || lat !== 9 || dc !== 1) begin
                errors++;
                $display("FAIL sweep_%0d: got bcd=%h ovf=%b lat=%0d pulses=%0d, want %h/0/9/1",
                         v, b, o, lat, dc, exp_b);
            end
            checks++;
            if (bc !== 9) begin
                errors++; $display("FAIL sweep_busy_%0d: got %0d cycles, want 9", v, bc);
            end
            checks++;
            if (b2 !== exp_b2 || o2 !== exp_o2) begin
                errors++;
                $display("FAIL sweep2_%0d: got bcd=%h ovf=%b, want %h/%b",
                         v, b2, o2, exp_b2, exp_o2);
            end
        end
    endtask

    task automatic test_start_ignored();
        int dc;
        logic [11:0] cap;
        dc  = 0;
        cap = 'x;
        @(negedge clk);
        start = 1'b1;
        bin   = 8'd42;
        @(posedge clk);
        #1;
        for (int k = 0; k <= 12; k++) begin
            if (k > 0) begin
                @(posedge clk);
                #1;
            end
            if (k == 2) bin = 8'd200;
            if (done === 1'b1) begin
                dc++;
                cap   = bcd;
                start = 1'b0;  // released before the IDLE edge so nothing new starts
            end
        end
        start = 1'b0;
        checks++;
        if (dc !== 1) begin
            errors++; $display("FAIL ignore_pulses: got %0d, want 1", dc);
        end
        checks++;
        if (cap !== 12'h042 || bcd !== 12'h042) begin
            errors++; $display("FAIL ignore_value: got %h (now %h), want 042", cap, bcd);
        end
    endtask

    task automatic test_reset_mid();
        logic [11:0] b; logic o; logic [7:0] b2; logic o2; int lat, bc, dc;
        int pulses;
        @(negedge clk);
        start = 1'b1;
        bin   = 8'd123;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({busy, done, bcd, ovf} !== 15'd0) begin
            errors++;
            $display("FAIL midreset_outputs: got busy=%b done=%b bcd=%h ovf=%b, want all zero",
                     busy, done, bcd, ovf);
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n  = 1'b1;
        pulses = 0;
        for (int k = 0; k < 12; k++) begin
            @(posedge clk);
            #1;
            if (done !== 1'b0 || busy !== 1'b0) pulses++;
        end
        checks++;
        if (pulses !== 0) begin
            errors++; $display("FAIL midreset_no_done: got %0d active cycles, want 0", pulses);
        end
        do_conv(8'd7, b, o, b2, o2, lat, bc, dc);
        checks++;
        if (b !== 12'h007 || o !== 1'b0 || lat !== 9) begin
            errors++;
            $display("FAIL midreset_after: got bcd=%h ovf=%b lat=%0d, want 007/0/9", b, o, lat);
        end
    endtask

    task automatic test_two_digit();
        logic [11:0] b; logic o; logic [7:0] b2; logic o2; int lat, bc, dc;
        do_conv(8'd255, b, o, b2, o2, lat, bc, dc);
        checks++;
        if (b2 !== 8'h55 || o2 !== 1'b1) begin
            errors++; $display("FAIL two_digit_255: got bcd=%h ovf=%b, want 55/1", b2, o2);
        end
        do_conv(8'd99, b, o, b2, o2, lat, bc, dc);
        checks++;
        if (b2 !== 8'h99 || o2 !== 1'b0) begin
            errors++; $display("FAIL two_digit_99: got bcd=%h ovf=%b, want 99/0", b2, o2);
        end
        do_conv(8'd100, b, o, b2, o2, lat, bc, dc);
        checks++;
        if (b2 !== 8'h00 || o2 !== 1'b1) begin
            errors++; $display("FAIL two_digit_100: got bcd=%h ovf=%b, want 00/1", b2, o2);
        end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        test_reset();
        test_zero();
        test_back_to_back();
        test_sweep();
        test_start_ignored();
        test_reset_mid();
        test_two_digit();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
